// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data, memory and status signals around the shared-memory arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        busy;
    logic        err;
    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_size, d_addr, d_wdata, mem_rdata, mem_valid,
        output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_wr, mem_size, mem_addr, mem_wdata, busy, err
    );
    modport master (
        output if_req, if_addr, d_req, d_wr, d_size, d_addr, d_wdata, mem_rdata, mem_valid,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_wr, mem_size, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and data access,
// round-robin on ties, with a per-access timeout that completes the access with err set.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t        state;
    logic [CW-1:0] counter;
    logic          lastGrant;
    logic          grantD;
    // lastGrant: 0 = fetch, 1 = data; a tie goes to the port not served last
    assign grantD   = bus.d_req && (!bus.if_req || !lastGrant);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            lastGrant     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_size  <= 2'b00;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_ready  <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_en   <= 1'b0;
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            case (state)
                IDLE: if (bus.if_req || bus.d_req) begin
                    state         <= grantD ? BUSY_D : BUSY_I;
                    lastGrant     <= grantD;
                    counter       <= '0;
                    bus.err       <= 1'b0;
                    bus.mem_en    <= 1'b1;
                    bus.mem_wr    <= grantD && bus.d_wr;
                    bus.mem_size  <= grantD ? bus.d_size : 2'b11;
                    bus.mem_addr  <= grantD ? bus.d_addr : bus.if_addr;
                    bus.mem_wdata <= grantD ? bus.d_wdata : '0;
                end
                BUSY_I, BUSY_D: if (bus.mem_valid || counter == CW'(TIMEOUT - 1)) begin
                    // mem_valid beats a simultaneous timeout
                    state        <= DONE;
                    bus.err      <= !bus.mem_valid;
                    bus.if_ready <= state == BUSY_I;
                    bus.d_ready  <= state == BUSY_D;
                    bus.if_rdata <= (bus.mem_valid && state == BUSY_I) ? bus.mem_rdata : bus.if_rdata;
                    bus.d_rdata  <= (bus.mem_valid && state == BUSY_D && !bus.mem_wr) ? bus.mem_rdata : bus.d_rdata;
                end else begin
                    counter <= counter + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: stimulus queues the expected memory requests and responses; a monitor pops and
// compares them whenever mem_en or a ready is seen.
module tb_mem_arbiter;
    typedef struct packed {logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} memReq_t;
    typedef struct packed {logic isData; logic [31:0] ifRdata; logic [31:0] dRdata; logic err;} rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    logic [31:0] memWord = '0;
    logic [31:0] expIf = '0;
    logic [31:0] expD = '0;
    memReq_t     memQ[$];
    rsp_t        rspQ[$];
    memReq_t     em;
    rsp_t        er;

    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_mem"}, 128'({bus.mem_en, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}), '0);
        chk({tag, "_port"}, 128'({bus.if_rdata, bus.d_rdata, bus.if_ready, bus.d_ready, bus.err, bus.busy}), '0);
    endtask

    task automatic expectAccess(input logic isData, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic err);
        memQ.push_back('{wr, size, addr, wdata});
        rspQ.push_back('{isData, expIf, expD, err});
    endtask

    task automatic waitReady(input logic isData, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(isData ? bus.d_ready : bus.if_ready) && n < budget);
        if (!(isData ? bus.d_ready : bus.if_ready)) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: no ready within %0d cycles, required one", budget);
        end
    endtask

    // memory model: mem_valid in the lat-th BUSY cycle, lat == 0 never answers
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_en && lat > 0) begin
                repeat (lat - 1) @(posedge clk);
                #1;
                bus.mem_valid = 1'b1;
                bus.mem_rdata = memWord;
                @(posedge clk);
                #1;
                bus.mem_valid = 1'b0;
                bus.mem_rdata = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_en) begin
                if (memQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_en_unexpected: got mem_en addr %h, required no access", bus.mem_addr);
                end else begin
                    em = memQ.pop_front();
                    chk("mem_req", 128'({bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}), 128'(em));
                end
            end
            if (bus.if_ready || bus.d_ready) begin
                if (rspQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_unexpected: got if_ready=%b d_ready=%b, required none", bus.if_ready, bus.d_ready);
                end else begin
                    er = rspQ.pop_front();
                    chk("rsp", 128'({bus.if_ready, bus.d_ready, bus.if_rdata, bus.d_rdata, bus.err}),
                        128'({~er.isData, er}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_wr = 1'b0;
        bus.d_size = 2'b00;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        checkReset("reset_initial");
        reset = 1'b0;

        // lone fetch
        memWord = 32'hDEADBEEF;
        expIf = memWord;
        expectAccess(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 1'b0);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        waitReady(1'b0, 10, n);
        chk("fetch_latency", 128'(n), 128'(2));
        bus.if_req = 1'b0;

        // tie after reset: store first, then fetch
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkReset("reset_pulse");
        reset = 1'b0;
        expIf = '0;
        expD = '0;
        memWord = 32'h11111111;
        expectAccess(1'b1, 1'b1, 2'b00, 32'h2000, 32'h55, 1'b0);
        expIf = memWord;
        expectAccess(1'b0, 1'b0, 2'b11, 32'h104, 32'h0, 1'b0);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h104;
        bus.d_req = 1'b1;
        bus.d_wr = 1'b1;
        bus.d_size = 2'b00;
        bus.d_addr = 32'h2000;
        bus.d_wdata = 32'h55;
        waitReady(1'b1, 10, n);
        chk("tie_data_latency", 128'(n), 128'(2));
        bus.d_req = 1'b0;
        bus.d_wr = 1'b0;
        waitReady(1'b0, 10, n);
        chk("rr_fetch_latency", 128'(n), 128'(3));
        bus.if_req = 1'b0;

        // timeout on a data read
        @(negedge clk);
        lat = 0;
        expectAccess(1'b1, 1'b0, 2'b10, 32'h3000, 32'h0, 1'b1);
        bus.d_req = 1'b1;
        bus.d_addr = 32'h3000;
        bus.d_size = 2'b10;
        bus.d_wdata = 32'h0;
        waitReady(1'b1, 10, n);
        chk("timeout_latency", 128'(n), 128'(5));
        bus.d_req = 1'b0;

        // err stays until the next grant, then clears
        @(negedge clk);
        lat = 1;
        memWord = 32'hCAFEF00D;
        expIf = memWord;
        expectAccess(1'b0, 1'b0, 2'b11, 32'h108, 32'h0, 1'b0);
        chk("err_held_idle", 128'(bus.err), 128'(1));
        bus.if_req = 1'b1;
        bus.if_addr = 32'h108;
        @(negedge clk);
        chk("err_cleared_on_grant", 128'(bus.err), 128'(0));
        waitReady(1'b0, 10, n);
        chk("err_clear_latency", 128'(n), 128'(1));
        bus.if_req = 1'b0;

        // mem_valid in the timeout cycle wins
        @(negedge clk);
        lat = 4;
        memWord = 32'h12345678;
        expD = memWord;
        expectAccess(1'b1, 1'b0, 2'b11, 32'h3004, 32'h0, 1'b0);
        bus.d_req = 1'b1;
        bus.d_addr = 32'h3004;
        bus.d_size = 2'b11;
        waitReady(1'b1, 10, n);
        chk("valid_at_timeout_latency", 128'(n), 128'(5));
        bus.d_req = 1'b0;

        // held fetch request with 3-cycle memory
        @(negedge clk);
        lat = 3;
        bus.if_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            memWord = 32'hA5A50000 + k;
            expIf = memWord;
            expectAccess(1'b0, 1'b0, 2'b11, 32'h200, 32'h0, 1'b0);
            bus.if_req = 1'b1;
            waitReady(1'b0, 12, n);
            chk(k == 0 ? "held_first_latency" : "held_period", 128'(n), 128'(k == 0 ? 4 : 5));
        end
        bus.if_req = 1'b0;

        // reset in BUSY_I, late mem_valid ignored
        @(negedge clk);
        lat = 3;
        memQ.push_back('{1'b0, 2'b11, 32'h300, 32'h0});
        bus.if_req = 1'b1;
        bus.if_addr = 32'h300;
        @(negedge clk);
        chk("busy_before_reset", 128'(bus.busy), 128'(1));
        #1;
        reset = 1'b1;
        bus.if_req = 1'b0;
        #1;
        checkReset("reset_async");
        @(negedge clk);
        reset = 1'b0;
        expIf = '0;
        expD = '0;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 128'({bus.busy, bus.if_ready, bus.if_rdata, bus.mem_en}), '0);

        chk("mem_queue_empty", 128'(memQ.size()), 128'(0));
        chk("rsp_queue_empty", 128'(rspQ.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as follows:
- clk  in  1  all state updates on its rising edge
- reset  in  1  asynchronous, active-high
REQ-002 The block SHALL have the following parameter:
- TIMEOUT, default 16, the number of BUSY cycles without mem_valid before the access is aborted.
REQ-003 The fetch port SHALL be: if_req in 1; if_addr in 32; if_rdata out 32; if_ready out 1.
- Fetch is always a 32-bit read.
REQ-004 The data port SHALL be: d_req in 1; d_wr in 1 (1=store); d_size in 2; d_addr in 32; d_wdata in 32; d_rdata out 32; d_ready out 1.
REQ-005 The memory port SHALL be: mem_en out 1; mem_wr out 1; mem_size out 2; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_valid in 1.
REQ-006 The status port SHALL be: busy out 1 (state != IDLE); err out 1 (timeout flag, valid while a ready signal is high).

Function
REQ-007 The block SHALL share one single-ported memory between pipeline fetch and data access.
REQ-008 Requesters SHALL hold req, addr, wr, size and wdata stable from assertion until their ready is seen high.
REQ-009 Each requester SHALL deassert req, or present a new request, on the edge where it sees ready.
REQ-010 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, DONE.
REQ-011 In IDLE with only d_req high, the FSM SHALL go to BUSY_D.
REQ-012 In IDLE with only if_req high, the FSM SHALL go to BUSY_I.
REQ-013 In IDLE with neither request high, the FSM SHALL stay in IDLE.
REQ-014 In IDLE with both requests high, the grant SHALL go to the port not granted last, tracked in a last_grant register updated on every grant.
REQ-015 On the grant edge, the block SHALL register mem_addr, mem_wr, mem_size and mem_wdata from the granted port.
- For fetch: mem_wr=0, mem_size=2'b11, mem_wdata=0.
REQ-016 mem_en SHALL be high for exactly the first cycle of BUSY_I or BUSY_D and low at all other times.
REQ-017 The mem_* address, control and data outputs SHALL hold their values until the next grant.
REQ-018 In BUSY_x, mem_valid high SHALL cause the FSM to go to DONE.
REQ-019 In BUSY_x with mem_valid high on a read, the block SHALL capture mem_rdata into if_rdata or d_rdata.
REQ-020 d_rdata SHALL NOT change on stores; the rdata of the non-granted port SHALL never change.
REQ-021 mem_valid outside BUSY_x SHALL be ignored.
REQ-022 A counter SHALL clear on entry to BUSY_x and increment each BUSY cycle.
REQ-023 When the counter reaches TIMEOUT-1 without mem_valid, the FSM SHALL go to DONE with err set and rdata unchanged.
REQ-024 mem_valid arriving in the same cycle as the timeout SHALL win: err=0 and the data is captured.
REQ-025 In DONE, the block SHALL assert the granted port's ready for exactly one cycle and then go to IDLE.
- Requests are not sampled in DONE, so a held req is never double-granted.
REQ-026 err SHALL be cleared on the next grant.
REQ-027 Minimum latency SHALL be: request seen in IDLE at edge N; mem_en high cycle N+1; mem_valid in cycle N+1 gives ready in cycle N+2.
- Back-to-back accesses take 3 cycles each.
REQ-028 The 32-bit address and data SHALL pass through unmodified; byte alignment is the requester's job.

Reset
REQ-029 While reset is high, regardless of clk, the block SHALL force:
- state=IDLE
- mem_en=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wdata=0
- if_rdata=0, d_rdata=0
- if_ready=0, d_ready=0
- err=0, busy=0
- counter=0
- last_grant=fetch (first tie goes to data)
REQ-030 Reset asserted mid-access SHALL abandon the access with no ready pulse.
- A mem_valid arriving after reset release SHALL be ignored.

Verification
REQ-031 Lone fetch:
- Stimulus: if_req=1, if_addr=0x100; memory returns 0xDEADBEEF one cycle after mem_en.
- Response: mem_en one cycle, mem_addr=0x100, mem_wr=0; if_ready one cycle with if_rdata=0xDEADBEEF; 3 cycles total.
REQ-032 Tie then round-robin:
- Stimulus: after reset, if_req and d_req both held high (d_wr=1, d_addr=0x2000, d_wdata=0x55, d_size=2'b00).
- Response: data granted first (mem_wr=1, mem_wdata=0x55); fetch granted next; d_rdata stays 0.
REQ-033 Timeout:
- Stimulus: TIMEOUT=4, d_req read, mem_valid never asserted.
- Response: d_ready and err high in the same cycle, 5 cycles after the grant edge; d_rdata unchanged; err clears on the next grant.
REQ-034 Reset mid-access:
- Stimulus: reset pulsed in BUSY_I; mem_valid asserted after reset release.
- Response: all outputs at reset values; no if_ready; FSM remains IDLE.
REQ-035 Held request:
- Stimulus: if_req held high continuously; memory latency 3 cycles.
- Response: one grant per access; DONE separates accesses; no double grant; mem_en pulses every 5 cycles.
